// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetch-side consumer of the PC register.
// Samples the PC, runs one SRAM-like instruction-bus transaction at a time
// (req/addr_ok/data_ok) and holds the returned word in a one-entry buffer for
// decode. Flush drops the buffered word and any response still in flight.
// Optional feature macro: INST_ADEL_EN (misaligned-fetch trap, adds if_adel).
//
// Handshake semantics:
//   bus   - inst_req is high exactly while in REQ; inst_addr is stable for the
//           whole REQ period and the request completes on inst_addr_ok=1.
//           The transaction then ends on the first inst_data_ok=1 seen in WAIT.
//           At most one transaction is outstanding; data_ok outside WAIT is
//           ignored.
//   decode- if_valid qualifies if_inst/if_pc; decode consumes the entry on any
//           edge where stall=0. While stall=1 the entry is held unchanged.
//   pc    - pc_advance is a one-cycle pulse, coincident with the new entry
//           appearing, telling the PC register it may load the next address.

module inst_fetch_ctrl #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] pc,
    input  logic             stall,
    input  logic             flush,
    output logic             pc_advance,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_inst,
    output logic [WIDTH-1:0] if_pc
`ifdef INST_ADEL_EN
    ,
    output logic             if_adel
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             discard_q, discard_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] inst_q, inst_d;
    logic [WIDTH-1:0] ifpc_q, ifpc_d;
    logic             adv_q, adv_d;
    logic             adel_q, adel_d;

    logic             buf_free;
    logic             capture;
    logic             adel_trap;

`ifndef INST_ADEL_EN
    // Without the trap the low PC bits are simply masked off the bus address.
    logic pc_lo_unused;
    assign pc_lo_unused = ^pc[1:0];
`endif

    // Next-state logic for the bus FSM plus the output buffer.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        ifpc_d    = ifpc_q;
        adv_d     = 1'b0;
        adel_d    = adel_q;
        capture   = 1'b0;
        adel_trap = 1'b0;

        // A trapped misaligned fetch is not consumed by decode; only flush
        // releases it.
        buf_free = !valid_q || (!stall && !adel_q);

        case (state_q)
            S_IDLE: begin
                if (buf_free && !flush) begin
`ifdef INST_ADEL_EN
                    if (pc[1:0] != 2'b00) begin
                        adel_trap = 1'b1;
                    end else begin
                        addr_d  = {pc[WIDTH-1:2], 2'b00};
                        state_d = S_REQ;
                    end
`else
                    addr_d  = {pc[WIDTH-1:2], 2'b00};
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                // The request cannot be withdrawn once raised; remember to
                // throw its response away instead.
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (inst_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                    capture   = !discard_q && !flush;
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                discard_d = 1'b0;
            end
        endcase

        if (capture) begin
            valid_d = 1'b1;
            inst_d  = inst_rdata;
            ifpc_d  = addr_q;
            adel_d  = 1'b0;
            adv_d   = 1'b1;
        end else if (adel_trap) begin
            valid_d = 1'b1;
            inst_d  = '0;
            ifpc_d  = pc;
            adel_d  = 1'b1;
        end else if (flush) begin
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end else if (!stall && !adel_q) begin
            valid_d = 1'b0;
        end
    end

    // State and buffer registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            ifpc_q    <= RESET_PC;
            adv_q     <= 1'b0;
            adel_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            ifpc_q    <= ifpc_d;
            adv_q     <= adv_d;
            adel_q    <= adel_d;
        end
    end

    assign inst_req   = (state_q == S_REQ);
    assign inst_addr  = addr_q;
    assign pc_advance = adv_q;
    assign if_valid   = valid_q;
    assign if_inst    = inst_q;
    assign if_pc      = ifpc_q;
`ifdef INST_ADEL_EN
    assign if_adel    = adel_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed scenarios followed by a randomized run against
// a transaction-level model of the fetch unit (bus slave + expected queue).
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  // clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [31:0] pc;
  logic        stall, flush;
  logic        pc_advance, inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;
`ifdef INST_ADEL_EN
  logic        if_adel;
`endif

  inst_fetch_ctrl #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .resetn(resetn), .pc(pc), .stall(stall), .flush(flush),
    .pc_advance(pc_advance), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .if_valid(if_valid), .if_inst(if_inst),
`ifdef INST_ADEL_EN
    .if_pc(if_pc), .if_adel(if_adel)
`else
    .if_pc(if_pc)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // bus slave and stimulus knobs
  bit          rnd_mode = 0;
  bit          fix_rdata = 1;
  logic [31:0] rdata_val = 32'h2408_0001;
  int          addr_dly = 0, data_dly = 0;
  int          a_cnt = 0, d_cnt = 0;
  bit          d_pend = 0;
  logic [31:0] d_data = '0;

  function automatic logic [31:0] rand_pc();
    logic [31:0] v;
    v = $urandom;
`ifdef INST_ADEL_EN
    v[1:0] = 2'b00;
`endif
    return v;
  endfunction

  // One clock: inputs are updated 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_mode) begin
      stall = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if (pc_advance || $urandom_range(0, 7) == 0) pc = rand_pc();
    end else if (pc_advance) begin
      pc = pc + 32'd4;
    end
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = $urandom;
    if (d_pend) begin
      if (d_cnt == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata   = d_data;
        d_pend       = 0;
      end else begin
        d_cnt--;
      end
    end else begin
      if (inst_req) begin
        if (a_cnt == 0) begin
          inst_addr_ok = 1'b1;
          d_pend = 1;
          d_cnt  = rnd_mode ? $urandom_range(0, 3) : data_dly;
          d_data = fix_rdata ? rdata_val : $urandom;
          a_cnt  = rnd_mode ? $urandom_range(0, 3) : addr_dly;
        end else begin
          a_cnt--;
        end
      end
      if (rnd_mode && $urandom_range(0, 9) == 0) inst_data_ok = 1'b1;
    end
  endtask

  task automatic wait_adv(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!pc_advance && cycles < 20);
  endtask

  // scoreboard / monitor: transaction-level model of the fetch unit
  bit          mon_en = 1;
  logic [63:0] exp_q[$];
  bit          txn_live, txn_acc, txn_drop;
  logic [31:0] txn_addr;
  bit          cap_due, exp_valid, hold_due, launch_ok, idle_now, push;
  logic [31:0] prev_pc, held_inst, held_pc;

  initial begin
    forever begin
      @(negedge clk);
      if (!resetn || !mon_en) begin
        exp_q.delete();
        txn_live = 0; txn_acc = 0; txn_drop = 0;
        cap_due = 0; exp_valid = 0; hold_due = 0; launch_ok = 0;
        prev_pc = pc;
      end else begin
        check("pc_advance_timing", pc_advance, cap_due);
        if (pc_advance) begin
          if (exp_q.size() == 0) begin
            check("advance_without_fetch", 32'(exp_q.size()), 1);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("sb_if_inst", if_inst, e[31:0]);
            check("sb_if_pc", if_pc, e[63:32]);
          end
        end
        check("if_valid", if_valid, exp_valid);
        if (hold_due) begin
          check("stall_hold_inst", if_inst, held_inst);
          check("stall_hold_pc", if_pc, held_pc);
        end
        if (inst_req && !txn_live) begin
          check("launch_allowed", launch_ok, 1);
          txn_live = 1; txn_acc = 0; txn_drop = 0;
          txn_addr = {prev_pc[31:2], 2'b00};
          check("req_addr", inst_addr, txn_addr);
        end else if (inst_req) begin
          check("req_addr_stable", inst_addr, txn_addr);
        end
        idle_now = !txn_live;
        // model update from this cycle's inputs
        push = 0;
        if (txn_live && flush) txn_drop = 1;
        if (txn_live && txn_acc && inst_data_ok) begin
          if (!txn_drop) begin
            exp_q.push_back({txn_addr, inst_rdata});
            push = 1;
          end
          txn_live = 0;
        end
        if (txn_live && inst_req && inst_addr_ok) txn_acc = 1;
        cap_due   = push;
        exp_valid = push ? 1'b1 : (flush ? 1'b0 : (stall ? exp_valid : 1'b0));
        hold_due  = if_valid && stall && !flush;
        held_inst = if_inst;
        held_pc   = if_pc;
        launch_ok = idle_now && (!if_valid || !stall) && !flush;
        prev_pc   = pc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  int lat, req_cycles, n;
  bit seen_adv, seen_valid;
  logic [31:0] h_inst, h_pc;

  initial begin
    resetn = 1'b0; pc = RST_PC; stall = 0; flush = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inst_req", inst_req, 0);
    check("rst_inst_addr", inst_addr, 0);
    check("rst_pc_advance", pc_advance, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_inst", if_inst, 0);
    check("rst_if_pc", if_pc, RST_PC);

    // first fetch, zero-wait bus
    resetn = 1'b1;
    wait_adv(lat);
    check("first_latency", lat, 3);
    check("first_if_valid", if_valid, 1);
    check("first_if_inst", if_inst, 32'h2408_0001);
    check("first_if_pc", if_pc, RST_PC);
    a_cnt = 3;
    rdata_val = 32'h1111_2222;
    step();
    check("single_pulse", pc_advance, 0);

    // addr_ok delayed by 3 cycles
    req_cycles = 0;
    for (int i = 0; i < 20 && inst_req; i++) begin
      req_cycles++;
      check("delayed_addr", inst_addr, 32'hBFC0_0004);
      step();
    end
    check("req_hold_cycles", req_cycles, 4);
    wait_adv(lat);
    check("delayed_capture", pc_advance, 1);
    check("delayed_if_inst", if_inst, 32'h1111_2222);
    check("delayed_if_pc", if_pc, 32'hBFC0_0004);

    // decode stall for 5 cycles after capture
    stall = 1;
    h_inst = if_inst; h_pc = if_pc;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_no_req", inst_req, 0);
      check("stall_no_adv", pc_advance, 0);
      check("stall_valid", if_valid, 1);
      check("stall_inst", if_inst, h_inst);
      check("stall_pc", if_pc, h_pc);
    end
    step();
    stall = 0; data_dly = 2; rdata_val = 32'hDEAD_BEEF;
    check("stall_drop_no_req", inst_req, 0);
    check("stall_drop_valid", if_valid, 1);
    step();
    check("req_after_stall", inst_req, 1);
    check("req_after_stall_addr", inst_addr, 32'hBFC0_0008);
    check("buffer_consumed", if_valid, 0);

    // flush while waiting for data
    step();
    flush = 1; pc = 32'hBFC0_0100;
    step();
    flush = 0;
    seen_adv = 0; seen_valid = 0; n = 0;
    while (!inst_req && n < 20) begin
      if (pc_advance) seen_adv = 1;
      if (if_valid) seen_valid = 1;
      step();
      n++;
    end
    check("flush_no_adv", seen_adv, 0);
    check("flush_no_valid", seen_valid, 0);
    check("flush_next_req", inst_req, 1);
    check("flush_next_addr", inst_addr, 32'hBFC0_0100);

    // reset in the middle of WAIT
    rdata_val = 32'h3333_4444;
    step();
    #2 resetn = 1'b0;
    #1;
    check("midrst_inst_req", inst_req, 0);
    check("midrst_inst_addr", inst_addr, 0);
    check("midrst_pc_advance", pc_advance, 0);
    check("midrst_if_valid", if_valid, 0);
    check("midrst_if_inst", if_inst, 0);
    check("midrst_if_pc", if_pc, RST_PC);
    step();
    pc = 32'hBFC0_0200;
    resetn = 1'b1;
    wait_adv(lat);
    check("postrst_capture", pc_advance, 1);
    check("postrst_if_inst", if_inst, 32'h3333_4444);
    check("postrst_if_pc", if_pc, 32'hBFC0_0200);

`ifdef INST_ADEL_EN
    // misaligned fetch trap
    mon_en = 0;
    pc = 32'hBFC0_0002;
    step();
    for (int i = 0; i < 3; i++) begin
      check("adel_no_req", inst_req, 0);
      check("adel_valid", if_valid, 1);
      check("adel_flag", if_adel, 1);
      check("adel_inst", if_inst, 0);
      check("adel_pc", if_pc, 32'hBFC0_0002);
      check("adel_no_adv", pc_advance, 0);
      step();
    end
    flush = 1; pc = 32'hBFC0_0300;
    step();
    flush = 0;
    check("adel_flush_valid", if_valid, 0);
    check("adel_flush_flag", if_adel, 0);
    mon_en = 1;
`endif

    // randomized traffic
    fix_rdata = 0;
    rnd_mode = 1;
    repeat (3000) step();
    rnd_mode = 0; stall = 0; flush = 0; addr_dly = 0; data_dly = 0;
    repeat (30) step();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
